// File: rtl/bp_pkg.sv
// Shared types and defaults for the BP game scheduler.
package bp_pkg;

  localparam int unsigned ROWS_DEF = 64;
  localparam int unsigned ACTS_DEF = 63;
  localparam int unsigned WDOG_DEF = 200;

  localparam int unsigned MAP_W  = 4;
  localparam int unsigned ROW_W  = 6;
  localparam int unsigned GUY_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACT_W  = 2;
  localparam int unsigned ADDR_W = MAP_W + ROW_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_FEED    = 3'd2,
    S_WAIT    = 3'd3,
    S_COLLECT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACT_STOP  = 2'd0,
    ACT_RIGHT = 2'd1,
    ACT_LEFT  = 2'd2,
    ACT_JUMP  = 2'd3
  } act_t;

  typedef enum logic [1:0] {
    OBS_NONE = 2'd0,
    OBS_LOW  = 2'd1,
    OBS_HIGH = 2'd2,
    OBS_FULL = 2'd3
  } obs_t;

  // ROM address of one map row.
  function automatic logic [ADDR_W-1:0] rom_index(input logic [MAP_W-1:0] map,
                                                  input logic [ROW_W-1:0] row);
    return {map, row};
  endfunction

endpackage

// File: rtl/bp_sched_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       adv_i,
  output logic [1:0] gnt_c_o
);

  logic ptr_q;

  // Tie goes to the pointer; a lone request always wins.
  always_comb begin
    gnt_c_o = req_i;
    if (req_i == 2'b11) begin
      gnt_c_o = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a grant the other requester gets priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (adv_i && (gnt_c_o != 2'b00)) begin
      ptr_q <= gnt_c_o[0];
    end
  end

endmodule

// File: rtl/bp_sched.sv
// Game scheduler: arbitrates two requesters, feeds map rows to the BP engine,
// then forwards its action stream with a first-response watchdog.
module bp_sched
  import bp_pkg::*;
#(
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned ACTS = ACTS_DEF,
  parameter int unsigned WDOG = WDOG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [MAP_W-1:0]  req_map0,
  input  logic [MAP_W-1:0]  req_map1,
  input  logic [GUY_W-1:0]  req_guy0,
  input  logic [GUY_W-1:0]  req_guy1,
  output logic [1:0]        grant,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              bp_in_valid,
  output logic [GUY_W-1:0]  bp_guy,
  output logic [DATA_W-1:0] bp_row,
  input  logic              bp_out_valid,
  input  logic [ACT_W-1:0]  bp_out,
  output logic              act_valid,
  output logic [ACT_W-1:0]  act,
  output logic              act_id,
  output logic              done,
  output logic              err,
  output logic              busy
);

  localparam int unsigned WD_W  = $clog2(WDOG + 1);
  localparam int unsigned CNT_W = $clog2(ACTS + 1);

  state_t             state_q;
  logic               id_q;
  logic [MAP_W-1:0]   map_q;
  logic [GUY_W-1:0]   guy_q;
  logic [ROW_W-1:0]   row_q;
  logic [ROW_W-1:0]   row_d;
  logic [WD_W-1:0]    wd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         grant_q;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               bp_in_valid_q;
  logic [GUY_W-1:0]   bp_guy_q;
  logic [DATA_W-1:0]  bp_row_q;
  logic               act_valid_q;
  logic [ACT_W-1:0]   act_q;
  logic               act_id_q;
  logic               done_q;
  logic               err_q;
  logic               busy_q;

  logic [1:0]         arb_gnt_c;
  logic               arb_adv_c;
  logic [MAP_W-1:0]   sel_map_c;
  logic [GUY_W-1:0]   sel_guy_c;

  assign arb_adv_c = (state_q == S_GRANT);
  assign sel_map_c = arb_gnt_c[1] ? req_map1 : req_map0;
  assign sel_guy_c = arb_gnt_c[1] ? req_guy1 : req_guy0;
  assign row_d     = row_q + ROW_W'(1);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .adv_i   (arb_adv_c),
    .gnt_c_o (arb_gnt_c)
  );

  // Game FSM with its counters and registered outputs; pulses default low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      id_q          <= 1'b0;
      map_q         <= '0;
      guy_q         <= '0;
      row_q         <= '0;
      wd_q          <= '0;
      cnt_q         <= '0;
      grant_q       <= '0;
      rom_addr_q    <= '0;
      bp_in_valid_q <= 1'b0;
      bp_guy_q      <= '0;
      bp_row_q      <= '0;
      act_valid_q   <= 1'b0;
      act_q         <= '0;
      act_id_q      <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      grant_q       <= '0;
      bp_in_valid_q <= 1'b0;
      bp_guy_q      <= '0;
      act_valid_q   <= 1'b0;
      act_q         <= '0;
      act_id_q      <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req != 2'b00) begin
            state_q <= S_GRANT;
            busy_q  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (arb_gnt_c != 2'b00) begin
            grant_q    <= arb_gnt_c;
            id_q       <= arb_gnt_c[1];
            map_q      <= sel_map_c;
            guy_q      <= sel_guy_c;
            row_q      <= '0;
            wd_q       <= '0;
            cnt_q      <= '0;
            rom_addr_q <= rom_index(sel_map_c, '0);
            state_q    <= S_FEED;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_FEED: begin
          bp_row_q      <= rom_rdata;
          bp_in_valid_q <= 1'b1;
          bp_guy_q      <= guy_q;
          if (row_q == ROW_W'(ROWS - 1)) begin
            rom_addr_q <= '0;
            wd_q       <= '0;
            state_q    <= S_WAIT;
          end else begin
            row_q      <= row_d;
            rom_addr_q <= rom_index(map_q, row_d);
          end
        end
        S_WAIT, S_COLLECT: begin
          if (bp_out_valid) begin
            act_valid_q <= 1'b1;
            act_q       <= bp_out;
            act_id_q    <= id_q;
            if (cnt_q == CNT_W'(ACTS - 1)) begin
              done_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= S_COLLECT;
            end
          end else if (state_q == S_COLLECT) begin
            // Stream broke before the full action count.
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (wd_q == WD_W'(WDOG - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign rom_addr    = rom_addr_q;
  assign bp_in_valid = bp_in_valid_q;
  assign bp_guy      = bp_guy_q;
  assign bp_row      = bp_row_q;
  assign act_valid   = act_valid_q;
  assign act         = act_q;
  assign act_id      = act_id_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bp_sched.sv
// Directed bench for bp_sched: combinational ROM model, scripted BP engine responses.
module tb_bp_sched;

  localparam int unsigned ROWS = 64;
  localparam int unsigned ACTS = 63;
  localparam int unsigned WDOG = 200;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [3:0]  req_map0, req_map1;
  logic [2:0]  req_guy0, req_guy1;
  logic [1:0]  grant;
  logic [9:0]  rom_addr;
  logic [15:0] rom_rdata;
  logic        bp_in_valid;
  logic [2:0]  bp_guy;
  logic [15:0] bp_row;
  logic        bp_out_valid;
  logic [1:0]  bp_out;
  logic        act_valid;
  logic [1:0]  act;
  logic        act_id;
  logic        done;
  logic        err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  bp_sched #(.ROWS(ROWS), .ACTS(ACTS), .WDOG(WDOG)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_map0     (req_map0),
    .req_map1     (req_map1),
    .req_guy0     (req_guy0),
    .req_guy1     (req_guy1),
    .grant        (grant),
    .rom_addr     (rom_addr),
    .rom_rdata    (rom_rdata),
    .bp_in_valid  (bp_in_valid),
    .bp_guy       (bp_guy),
    .bp_row       (bp_row),
    .bp_out_valid (bp_out_valid),
    .bp_out       (bp_out),
    .act_valid    (act_valid),
    .act          (act),
    .act_id       (act_id),
    .done         (done),
    .err          (err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map contents: a scrambled function of the address.
  function automatic logic [15:0] rom_f(input logic [9:0] a);
    logic [15:0] x;
    x = {6'd0, a};
    return (x * 16'd40503) ^ 16'h5A5A;
  endfunction

  assign rom_rdata = rom_f(rom_addr);

  // Action sequence the scripted BP engine emits.
  function automatic logic [1:0] pat(input int k);
    return 2'((k * 3 + k / 7) % 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One game: grant, 64-row feed, then watchdog (nacts=0), full run or early drop.
  task automatic game(input logic [1:0] exp_g, input logic [3:0] map, input logic [2:0] guy,
                      input logic id, input int nacts, input int rst_row,
                      input logic [1:0] req_after);
    int nt;
    int bad_a;
    int bad_v;
    int bad_q;
    logic [9:0] base;
    nt = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      nt = t;
      if (grant != 2'b00) break;
    end
    chk("grant_latency", 64'(nt), 64'(2));
    chk("grant_value", 64'(grant), 64'(exp_g));
    req = req_after;
    base = {map, 6'd0};
    bad_a = 0;
    bad_v = 0;
    bad_q = 0;
    for (int i = 0; i < 64; i++) begin
      if (rom_addr !== base + 10'(i)) bad_a++;
      if (i == 0) begin
        if (bp_in_valid !== 1'b0) bad_v++;
      end else if (bp_in_valid !== 1'b1 || bp_guy !== guy || bp_row !== rom_f(base + 10'(i - 1))) begin
        bad_v++;
      end
      if (act_valid !== 1'b0 || busy !== 1'b1 || (i > 0 && grant !== 2'b00)) bad_q++;
      if (i == rst_row) begin
        chk("pre_rst_addr", 64'(bad_a), 64'(0));
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", 64'({grant, rom_addr, bp_in_valid, bp_guy, bp_row,
                                    act_valid, act, act_id, done, err, busy}), 64'(0));
        return;
      end
      bp_out_valid = (i >= 10 && i < 13);
      tick();
    end
    if (bp_in_valid !== 1'b1 || bp_guy !== guy || bp_row !== rom_f(base + 10'd63)) bad_v++;
    chk("feed_addr", 64'(bad_a), 64'(0));
    chk("feed_in_valid", 64'(bad_v), 64'(0));
    chk("feed_quiet", 64'(bad_q), 64'(0));
    tick();
    chk("wait_in_idle", 64'({bp_in_valid, bp_guy, grant}), 64'(0));
    if (nacts == 0) begin
      bad_q = 0;
      for (int j = 2; j <= int'(WDOG); j++) begin
        tick();
        if (j < int'(WDOG) && (err !== 1'b0 || busy !== 1'b1)) bad_q++;
      end
      chk("wdog_quiet", 64'(bad_q), 64'(0));
      chk("wdog_err", 64'({err, done, busy}), 64'(3'b100));
      tick();
      chk("wdog_idle", 64'({err, busy}), 64'(0));
      return;
    end
    repeat (4) tick();
    bad_a = 0;
    for (int k = 0; k < nacts; k++) begin
      bp_out_valid = 1'b1;
      bp_out = pat(k);
      tick();
      if (act_valid !== 1'b1 || act !== pat(k) || act_id !== id) bad_a++;
      if (k < nacts - 1 && (done !== 1'b0 || err !== 1'b0)) bad_a++;
    end
    bp_out_valid = 1'b0;
    bp_out = 2'd0;
    chk("actions", 64'(bad_a), 64'(0));
    if (nacts == int'(ACTS)) begin
      chk("done_with_last_act", 64'({done, act_valid, err, busy}), 64'(4'b1100));
    end else begin
      chk("no_done_at_drop", 64'({done, err}), 64'(0));
      tick();
      chk("drop_err", 64'({err, done, act_valid}), 64'(3'b100));
      tick();
      chk("drop_idle", 64'({err, busy, done}), 64'(0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req = 2'b00;
    req_map0 = 4'd0;
    req_map1 = 4'd0;
    req_guy0 = 3'd0;
    req_guy1 = 3'd0;
    bp_out_valid = 1'b0;
    bp_out = 2'd0;
    repeat (3) tick();

    // Reset state.
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_bp_in", 64'({bp_in_valid, bp_guy}), 64'(0));
    chk("rst_bp_row", 64'(bp_row), 64'(0));
    chk("rst_act", 64'({act_valid, act, act_id}), 64'(0));
    chk("rst_done_err", 64'({done, err}), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    tick();

    // Engine output while idle is ignored.
    bp_out_valid = 1'b1;
    bp_out = 2'd3;
    tick();
    bp_out_valid = 1'b0;
    chk("idle_ignore", 64'({act_valid, busy, err, done}), 64'(0));

    // Requester 0 alone, map 3, guy 5.
    req_map0 = 4'd3;
    req_guy0 = 3'd5;
    req = 2'b01;
    game(2'b01, 4'd3, 3'd5, 1'b0, int'(ACTS), -1, 2'b00);

    // Requester 1 held throughout, requester 0 also asserted: 10, 01, 10.
    req_map0 = 4'd1;
    req_guy0 = 3'd2;
    req_map1 = 4'd9;
    req_guy1 = 3'd6;
    req = 2'b11;
    game(2'b10, 4'd9, 3'd6, 1'b1, int'(ACTS), -1, 2'b11);
    game(2'b01, 4'd1, 3'd2, 1'b0, int'(ACTS), -1, 2'b11);
    game(2'b10, 4'd9, 3'd6, 1'b1, int'(ACTS), -1, 2'b00);

    // Engine never answers.
    req_map0 = 4'd4;
    req_guy0 = 3'd1;
    req = 2'b01;
    game(2'b01, 4'd4, 3'd1, 1'b0, 0, -1, 2'b00);

    // Stream drops after 40 actions.
    req_map1 = 4'd7;
    req_guy1 = 3'd3;
    req = 2'b10;
    game(2'b10, 4'd7, 3'd3, 1'b1, 40, -1, 2'b00);

    // Reset at feed row 30.
    req_map0 = 4'd3;
    req_guy0 = 3'd5;
    req = 2'b01;
    game(2'b01, 4'd3, 3'd5, 1'b0, int'(ACTS), 30, 2'b00);
    tick();
    chk("rst_hold_outputs", 64'({grant, rom_addr, bp_in_valid, done, err, busy, act_valid}), 64'(0));

    // Both requesters together after reset: 01 first, then 10 two cycles after done.
    rst = 1'b0;
    req_map0 = 4'd2;
    req_guy0 = 3'd4;
    req_map1 = 4'd5;
    req_guy1 = 3'd7;
    req = 2'b11;
    game(2'b01, 4'd2, 3'd4, 1'b0, int'(ACTS), -1, 2'b10);
    game(2'b10, 4'd5, 3'd7, 1'b1, int'(ACTS), -1, 2'b00);
    repeat (3) tick();
    chk("final_idle", 64'({busy, grant, err, done}), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
